// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Payout end of the vending path. Takes the change amount computed by the
// price/payment subtractor and pays it out one coin at a time to the coin
// mechanism over a four-phase req/ack handshake. Coins are chosen greedily
// over four denominations (largest first). Each denomination has its own
// inventory, and those inventories are reloaded on reset or refill.
//
// Ports
//   CLOCK_50    in   1    system clock, all state on rising edge
//   reset_n     in   1    asynchronous active-low reset
//   start       in   1    1-cycle pulse: latch change_amt and begin payout
//   change_amt  in   AW   change to pay, sampled on start
//   refill      in   1    1-cycle pulse: reload inventories (IDLE/FAULT only)
//   coin_ack    in   1    mechanism acknowledge (four-phase)
//   coin_req    out  1    request one coin of coin_sel
//   coin_sel    out  2    denomination index, stable while coin_req=1
//   busy        out  1    payout in progress (SELECT/REQ/RELEASE)
//   done        out  1    1-cycle pulse: full amount paid
//   remaining   out  AW   amount still owed
//   err         out  2    00 none, 01 inventory cannot cover, 10 ack timeout
//   inv_empty   out  4    bit i = inventory of denomination i is zero
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int AW          = 5,
  parameter int D0          = 10,
  parameter int D1          = 5,
  parameter int D2          = 2,
  parameter int D3          = 1,
  parameter int INV_INIT    = 15,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] change_amt,
  input  logic          refill,
  input  logic          coin_ack,
  output logic          coin_req,
  output logic [1:0]    coin_sel,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] remaining,
  output logic [1:0]    err,
  output logic [3:0]    inv_empty
);

  localparam int         TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [3:0] INV_FULL = 4'(INV_INIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_INV  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    REQ,
    RELEASE,
    DONE,
    FAULT
  } state_e;

  state_e          state_q,     state_d;
  logic [AW-1:0]   remaining_q, remaining_d;
  logic [1:0]      coin_sel_q,  coin_sel_d;
  logic            coin_req_q,  coin_req_d;
  logic [1:0]      err_q,       err_d;
  logic [TW-1:0]   tmo_q,       tmo_d;
  logic [3:0]      inv_q [4];
  logic [3:0]      inv_d [4];

  logic            pick_found;
  logic [1:0]      pick_idx;

  // Coin value for a denomination index.
  function automatic logic [AW-1:0] den_value(input logic [1:0] idx);
    case (idx)
      2'd0:    den_value = AW'(D0);
      2'd1:    den_value = AW'(D1);
      2'd2:    den_value = AW'(D2);
      default: den_value = AW'(D3);
    endcase
  endfunction

  // Greedy pick: scanning from the smallest denomination upward and letting
  // later (lower-index, larger) hits overwrite earlier ones leaves the lowest
  // index that both fits the amount owed and still has coins in stock.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((den_value(2'(i)) <= remaining_q) && (inv_q[i] != 4'd0)) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_sel_d  = coin_sel_q;
    coin_req_d  = coin_req_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    inv_d       = inv_q;

    case (state_q)
      // FAULT behaves like IDLE for start/refill; it only keeps err and
      // remaining visible until the next start.
      IDLE, FAULT: begin
        if (refill) begin
          for (int i = 0; i < 4; i++) begin
            inv_d[i] = INV_FULL;
          end
        end
        if (start) begin
          remaining_d = change_amt;
          err_d       = ERR_NONE;
          state_d     = SELECT;
        end
      end

      SELECT: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (pick_found) begin
          coin_sel_d = pick_idx;
          coin_req_d = 1'b1;
          tmo_d      = '0;
          state_d    = REQ;
        end else begin
          err_d   = ERR_NO_INV;
          state_d = FAULT;
        end
      end

      // An ack in the same cycle as the last timeout cycle still counts as
      // a delivered coin: the mechanism has already released it.
      REQ: begin
        if (coin_ack) begin
          coin_req_d  = 1'b0;
          remaining_d = remaining_q - den_value(coin_sel_q);
          if (inv_q[coin_sel_q] != 4'd0) begin
            inv_d[coin_sel_q] = inv_q[coin_sel_q] - 4'd1;
          end
          tmo_d   = '0;
          state_d = RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          coin_req_d = 1'b0;
          err_d      = ERR_TIMEOUT;
          state_d    = FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RELEASE: begin
        if (!coin_ack) begin
          state_d = SELECT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also reloads every inventory.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      coin_sel_q  <= 2'd0;
      coin_req_q  <= 1'b0;
      err_q       <= ERR_NONE;
      tmo_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        inv_q[i] <= INV_FULL;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_sel_q  <= coin_sel_d;
      coin_req_q  <= coin_req_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      for (int i = 0; i < 4; i++) begin
        inv_q[i] <= inv_d[i];
      end
    end
  end

  assign coin_req  = coin_req_q;
  assign coin_sel  = coin_sel_q;
  assign remaining = remaining_q;
  assign err       = err_q;
  assign busy      = (state_q == SELECT) || (state_q == REQ) || (state_q == RELEASE);
  assign done      = (state_q == DONE);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      inv_empty[i] = (inv_q[i] == 4'd0);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Directed bench for change_dispenser. A small coin-mechanism responder acks
// each request after a chosen delay and logs the selected denominations and
// the remaining amount after each coin; the logs are compared with
// hand-computed greedy payouts.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  logic       CLOCK_50;
  logic       reset_n;
  logic       start;
  logic [4:0] change_amt;
  logic       refill;
  logic       coin_ack;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic [4:0] remaining;
  logic [1:0] err;
  logic [3:0] inv_empty;

  int check_count;
  int pass_count;
  int fail_count;

  logic [1:0] sel_log [$];
  logic [4:0] rem_log [$];
  bit         saw_done;
  int         first_req_cyc;
  logic [1:0] exp_s [8];
  logic [4:0] exp_r [8];
  int         req_cycles;
  bit         ended_ok;

  change_dispenser dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .start      (start),
    .change_amt (change_amt),
    .refill     (refill),
    .coin_ack   (coin_ack),
    .coin_req   (coin_req),
    .coin_sel   (coin_sel),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining),
    .err        (err),
    .inv_empty  (inv_empty)
  );

  // 50 MHz-style free-running clock.
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Global safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      pass_count++;
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Raise start with an amount; the caller drops it after the next edge.
  task automatic applyStimulus(input logic [4:0] amt);
    start      = 1'b1;
    change_amt = amt;
  endtask

  task automatic pulseRefill();
    refill = 1'b1;
    tick();
    refill = 1'b0;
  endtask

  // Start a payout and play the coin mechanism until done or fault.
  task automatic runPayout(input logic [4:0] amt, input int ack_delay);
    int wait_cnt;
    bit finished;
    sel_log.delete();
    rem_log.delete();
    saw_done      = 1'b0;
    first_req_cyc = -1;
    finished      = 1'b0;
    wait_cnt      = 0;
    applyStimulus(amt);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      start = 1'b0;
      if (done) begin
        saw_done = 1'b1;
        finished = 1'b1;
        break;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (coin_req && !coin_ack) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          sel_log.push_back(coin_sel);
          coin_ack = 1'b1;
          wait_cnt = 0;
        end
      end else if (!coin_req && coin_ack) begin
        rem_log.push_back(remaining);
        coin_ack = 1'b0;
      end
    end
    coin_ack = 1'b0;
    checkOutput($sformatf("payout_%0d_ends", amt), {31'd0, finished}, 32'd1);
    tick();
  endtask

  // Compare the logged coin sequence against exp_s / exp_r.
  task automatic checkCoins(input string tag, input int n, input bit with_rems);
    checkOutput({tag, "_ncoins"}, sel_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < sel_log.size())
        checkOutput($sformatf("%s_sel%0d", tag, i), {30'd0, sel_log[i]}, {30'd0, exp_s[i]});
      if (with_rems && (i < rem_log.size()))
        checkOutput($sformatf("%s_rem%0d", tag, i), {27'd0, rem_log[i]}, {27'd0, exp_r[i]});
    end
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    fail_count  = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    change_amt  = 5'd0;
    refill      = 1'b0;
    coin_ack    = 1'b0;

    // Reset values.
    tick();
    tick();
    checkOutput("rst_coin_req",  {31'd0, coin_req}, 32'd0);
    checkOutput("rst_coin_sel",  {30'd0, coin_sel}, 32'd0);
    checkOutput("rst_busy",      {31'd0, busy},     32'd0);
    checkOutput("rst_done",      {31'd0, done},     32'd0);
    checkOutput("rst_remaining", {27'd0, remaining}, 32'd0);
    checkOutput("rst_err",       {30'd0, err},      32'd0);
    checkOutput("rst_inv_empty", {28'd0, inv_empty}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 22 with full stock: 10,10,2.
    runPayout(5'd22, 2);
    exp_s = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_r = '{5'd12, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    checkCoins("t22", 3, 1'b1);
    checkOutput("t22_done",      {31'd0, saw_done}, 32'd1);
    checkOutput("t22_first_req", first_req_cyc, 32'd2);
    checkOutput("t22_err",       {30'd0, err}, 32'd0);
    checkOutput("t22_busy_after",{31'd0, busy}, 32'd0);
    checkOutput("t22_inv_empty", {28'd0, inv_empty}, 32'd0);

    // 31: 10,10,10,1.
    runPayout(5'd31, 2);
    exp_s = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_r = '{5'd21, 5'd11, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    checkCoins("t31", 4, 1'b1);
    checkOutput("t31_done", {31'd0, saw_done}, 32'd1);
    checkOutput("t31_err",  {30'd0, err}, 32'd0);

    // D0 stock is now 10; nine more leave exactly one coin.
    for (int k = 0; k < 3; k++) runPayout(5'd30, 1);
    checkOutput("d0_one_left_inv_empty", {28'd0, inv_empty}, 32'd0);
    runPayout(5'd10, 1);
    exp_s = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    checkCoins("t10", 1, 1'b0);
    checkOutput("d0_drained_inv_empty", {28'd0, inv_empty}, 32'd1);

    // 22 without tens: 5,5,5,5,2.
    runPayout(5'd22, 2);
    exp_s = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    exp_r = '{5'd17, 5'd12, 5'd7, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0};
    checkCoins("t22n", 5, 1'b1);
    checkOutput("t22n_done", {31'd0, saw_done}, 32'd1);

    // Refill in IDLE, then leave only D2 coins in stock.
    pulseRefill();
    checkOutput("refill_idle_inv_empty", {28'd0, inv_empty}, 32'd0);
    for (int k = 0; k < 5; k++)  runPayout(5'd30, 1);
    for (int k = 0; k < 5; k++)  runPayout(5'd15, 1);
    for (int k = 0; k < 15; k++) runPayout(5'd1, 1);
    checkOutput("only_d2_inv_empty", {28'd0, inv_empty}, 32'd11);

    // 3 with only twos: one coin, then inventory fault with 1 still owed.
    runPayout(5'd3, 2);
    exp_s = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_r = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    checkCoins("t3", 1, 1'b1);
    checkOutput("t3_no_done",   {31'd0, saw_done}, 32'd0);
    checkOutput("t3_err",       {30'd0, err}, 32'd1);
    checkOutput("t3_remaining", {27'd0, remaining}, 32'd1);
    checkOutput("t3_busy",      {31'd0, busy}, 32'd0);

    // Start from FAULT, then reset while the request is outstanding.
    applyStimulus(5'd2);
    tick();
    start = 1'b0;
    checkOutput("flt_start_err_clr", {30'd0, err}, 32'd0);
    checkOutput("flt_start_busy",    {31'd0, busy}, 32'd1);
    tick();
    checkOutput("pre_rst_coin_req", {31'd0, coin_req}, 32'd1);
    checkOutput("pre_rst_coin_sel", {30'd0, coin_sel}, 32'd2);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_coin_req",  {31'd0, coin_req}, 32'd0);
    checkOutput("async_rst_busy",      {31'd0, busy}, 32'd0);
    checkOutput("async_rst_done",      {31'd0, done}, 32'd0);
    checkOutput("async_rst_remaining", {27'd0, remaining}, 32'd0);
    checkOutput("async_rst_err",       {30'd0, err}, 32'd0);
    checkOutput("async_rst_coin_sel",  {30'd0, coin_sel}, 32'd0);
    checkOutput("async_rst_inv_empty", {28'd0, inv_empty}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 7 with the mechanism never acking: timeout after 1000 request cycles.
    // A second start mid-request must be ignored.
    applyStimulus(5'd7);
    req_cycles = 0;
    ended_ok   = 1'b0;
    for (int cyc = 1; cyc <= 1500; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 2) begin
        checkOutput("tmo_first_req", {31'd0, coin_req}, 32'd1);
        checkOutput("tmo_sel",       {30'd0, coin_sel}, 32'd1);
      end
      if (cyc == 5) applyStimulus(5'd3);
      if (coin_req) req_cycles++;
      if (!busy) begin
        ended_ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checkOutput("tmo_ends",       {31'd0, ended_ok}, 32'd1);
    checkOutput("tmo_req_cycles", req_cycles, 32'd1000);
    checkOutput("tmo_err",        {30'd0, err}, 32'd2);
    checkOutput("tmo_remaining",  {27'd0, remaining}, 32'd7);
    checkOutput("tmo_coin_req",   {31'd0, coin_req}, 32'd0);

    // Refill must not leave FAULT.
    pulseRefill();
    tick();
    checkOutput("flt_refill_err",  {30'd0, err}, 32'd2);
    checkOutput("flt_refill_busy", {31'd0, busy}, 32'd0);
    checkOutput("flt_refill_rem",  {27'd0, remaining}, 32'd7);

    // Amount 0 from FAULT: err clears, done two edges after start.
    applyStimulus(5'd0);
    tick();
    start = 1'b0;
    checkOutput("zero_err_clr", {30'd0, err}, 32'd0);
    checkOutput("zero_busy",    {31'd0, busy}, 32'd1);
    checkOutput("zero_done_n1", {31'd0, done}, 32'd0);
    tick();
    checkOutput("zero_done_n2", {31'd0, done}, 32'd1);
    checkOutput("zero_no_req",  {31'd0, coin_req}, 32'd0);
    checkOutput("zero_busy_n2", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("zero_done_n3", {31'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
